// File: rtl/regfile_write_queue_pkg.sv
// regfile_write_queue_pkg: shared widths, queue depth and queue entry type
package regfile_write_queue_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int WBQ_DEPTH  = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wbq_entry_t;
endpackage

// File: rtl/regfile_wb_fifo.sv
// regfile_wb_fifo: two-write one-read entry storage with pointers and occupancy
module regfile_wb_fifo
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                push_a,
    input  wbq_entry_t                          entry_a,
    input  logic                                push_b,
    input  wbq_entry_t                          entry_b,
    input  logic                                pop,
    output wbq_entry_t                          head,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    addrs,
    output logic [DEPTH-1:0]                    valid,
    output logic [$clog2(DEPTH):0]              count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbq_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, off;
    logic [CW-1:0]          count_q, count_d;

    // Next state: entry a (older) lands before entry b; pointers wrap naturally
    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        if (push_a) begin
            entries_d[wr_ptr_d] = entry_a;
            wr_ptr_d            = wr_ptr_d + PW'(1);
        end
        if (push_b) begin
            entries_d[wr_ptr_d] = entry_b;
            wr_ptr_d            = wr_ptr_d + PW'(1);
        end
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
    end

    // Head entry plus per-slot address and occupancy for the hazard compare
    always_comb begin
        off  = '0;
        head = entries_q[rd_ptr_q];
        for (int i = 0; i < DEPTH; i++) begin
            off      = PW'(i) - rd_ptr_q;
            addrs[i] = entries_q[i].addr;
            valid[i] = {1'b0, off} < count_q;
        end
        count = count_q;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is deliberately left unreset; occupancy alone marks validity
    always_ff @(posedge clock) begin
        entries_q <= entries_d;
    end
endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: merges load and ALU results into one register-file write per cycle
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    mem_valid,
    input  logic [REG_ADDR_W-1:0]   mem_addr,
    input  logic [REG_DATA_W-1:0]   mem_data,
    input  logic                    alu_valid,
    input  logic [REG_ADDR_W-1:0]   alu_addr,
    input  logic [REG_DATA_W-1:0]   alu_data,
    output logic                    mem_ready,
    output logic                    alu_ready,
    output logic                    WriteEnable,
    output logic [REG_ADDR_W-1:0]   write_address,
    output logic [REG_DATA_W-1:0]   write_data_in,
    input  logic [REG_ADDR_W-1:0]   read_address_1,
    input  logic [REG_ADDR_W-1:0]   read_address_2,
    output logic                    hazard_1,
    output logic                    hazard_2,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                             push_mem, push_alu;
    wbq_entry_t                       head;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] addrs;
    logic [DEPTH-1:0]                 valid;

    // Ready from current occupancy only; a pending mem request reserves a slot ahead of alu
    always_comb begin
        mem_ready = count <= CW'(DEPTH - 1);
        alu_ready = mem_valid ? count <= CW'(DEPTH - 2) : mem_ready;
        push_mem  = mem_valid && mem_ready && mem_addr != '0;
        push_alu  = alu_valid && alu_ready && alu_addr != '0;
    end

    // Write port straight from the head, and read-after-write hazard against every queued entry
    always_comb begin
        empty         = count == '0;
        full          = count == CW'(DEPTH);
        WriteEnable   = !empty;
        write_address = head.addr;
        write_data_in = head.data;
        hazard_1      = 1'b0;
        hazard_2      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hazard_1 = hazard_1 | (valid[i] && addrs[i] == read_address_1);
            hazard_2 = hazard_2 | (valid[i] && addrs[i] == read_address_2);
        end
        hazard_1 = hazard_1 && read_address_1 != '0;
        hazard_2 = hazard_2 && read_address_2 != '0;
    end

    regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_a  (push_mem),
        .entry_a ('{addr: mem_addr, data: mem_data}),
        .push_b  (push_alu),
        .entry_b ('{addr: alu_addr, data: alu_data}),
        .pop     (!empty),
        .head    (head),
        .addrs   (addrs),
        .valid   (valid),
        .count   (count)
    );
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed and random checks against a queue-based reference model
module tb_regfile_write_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_valid, alu_valid;
    logic [4:0]  mem_addr, alu_addr, write_address, read_address_1, read_address_2;
    logic [31:0] mem_data, alu_data, write_data_in;
    logic        mem_ready, alu_ready, WriteEnable, hazard_1, hazard_2, full, empty;
    logic [2:0]  count;

    ent_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    regfile_write_queue #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_valid      (mem_valid),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .alu_valid      (alu_valid),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .mem_ready      (mem_ready),
        .alu_ready      (alu_ready),
        .WriteEnable    (WriteEnable),
        .write_address  (write_address),
        .write_data_in  (write_data_in),
        .read_address_1 (read_address_1),
        .read_address_2 (read_address_2),
        .hazard_1       (hazard_1),
        .hazard_2       (hazard_2),
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_we"}, 32'(WriteEnable), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_haz1"}, 32'(hazard_1), 32'd0);
        chk({tag, "_haz2"}, 32'(hazard_2), 32'd0);
    endtask

    // One clock cycle: drive at posedge+1, check at posedge+4, advance model to the next edge
    task automatic cycle(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic [4:0] r1, input logic [4:0] r2);
        int sz;
        bit emr, ear, h1, h2;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        read_address_1 = r1; read_address_2 = r2;
        #3;
        sz  = q.size();
        emr = (DEPTH - sz) >= 1;
        ear = mv ? (DEPTH - sz) >= 2 : (DEPTH - sz) >= 1;
        h1 = 0; h2 = 0;
        foreach (q[i]) begin
            if (q[i].a == r1) h1 = 1;
            if (q[i].a == r2) h2 = 1;
        end
        h1 = h1 && r1 != 0;
        h2 = h2 && r2 != 0;
        chk("mem_ready", 32'(mem_ready), 32'(emr));
        chk("alu_ready", 32'(alu_ready), 32'(ear));
        chk("write_enable", 32'(WriteEnable), 32'(sz != 0));
        if (sz != 0) begin
            chk("write_address", 32'(write_address), 32'(q[0].a));
            chk("write_data", write_data_in, q[0].d);
        end
        chk("count", 32'(count), 32'(sz));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("hazard_1", 32'(hazard_1), 32'(h1));
        chk("hazard_2", 32'(hazard_2), 32'(h2));
        if (sz != 0) void'(q.pop_front());
        if (mv && emr && ma != 0) q.push_back('{a: ma, d: md});
        if (av && ear && aa != 0) q.push_back('{a: aa, d: ad});
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    // Asynchronous reset pulse between edges: write port must drop without waiting for a clock
    task automatic reset_mid(input logic [4:0] r1, input logic [4:0] r2);
        mem_valid = 0; alu_valid = 0;
        read_address_1 = r1; read_address_2 = r2;
        #1 reset_n = 1'b0;
        #1 chk_reset_state("mid_reset");
        q.delete();
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        read_address_1 = 5; read_address_2 = 7;
        #2 chk_reset_state("reset_pre_edge");
        @(posedge clock);
        #1 chk_reset_state("reset_post_edge");
        reset_n = 1'b1;
        // single mem request accepted on the first edge after reset release
        cycle(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5, 0);
        idle(3, 5, 0);
        // dual request: mem is older and drains first
        cycle(1, 3, 32'h11, 1, 4, 32'h22, 3, 4);
        idle(3, 3, 4);
        // backpressure: two dual cycles fill to 3, then alu must be refused while mem is valid
        cycle(1, 8, 32'hA1, 1, 9, 32'hA2, 8, 9);
        cycle(1, 10, 32'hA3, 1, 11, 32'hA4, 10, 11);
        cycle(1, 12, 32'hA5, 1, 13, 32'hA6, 12, 13);
        idle(5, 12, 13);
        // address zero is accepted but dropped
        cycle(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0);
        idle(2, 0, 0);
        // hazard tracking on a single queued write
        cycle(1, 7, 32'h77, 0, 0, 0, 7, 0);
        idle(2, 7, 0);
        // duplicate addresses are kept and drained in order
        cycle(1, 6, 32'h61, 1, 6, 32'h62, 6, 6);
        idle(3, 6, 0);
        // reset mid-drain with three entries queued
        cycle(1, 1, 32'h101, 1, 2, 32'h102, 1, 2);
        cycle(1, 3, 32'h103, 1, 4, 32'h104, 3, 4);
        reset_mid(3, 4);
        idle(3, 3, 4);
        // random traffic with small address range to provoke zero addresses and hazards
        for (int i = 0; i < 2000; i++) begin
            if (i % 500 == 250) reset_mid(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(4, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
